lsu_wb: RTL and testbench
=========================

LSU_WB -- requirements
Module: lsu_wb

Interface
REQ-001 Parameter DATA_W, 32, bus data width in bits; legal values 32 and 64.
REQ-002 Parameter ADDR_W, 32, byte address width.
REQ-003 Parameter ALLOW_MISALIGN, 1, 1 = split word-crossing accesses into two beats; 0 = fault them.
REQ-004 Parameter TIMEOUT, 0, number of stb cycles without ack before abort; 0 disables the timeout.
REQ-005 clk_i  input  1  clock; all state changes on the rising edge.
REQ-006 rst_i  input  1  reset, asynchronous, active-high.
REQ-007 req_i  input  1  core request strobe.
REQ-008 we_i  input  1  core request is a write.
REQ-009 size_i  input  2  access size: 0 byte, 1 half, 2 word, 3 dword (dword legal only when DATA_W=64).
REQ-010 signed_i  input  1  sign-extend read data.
REQ-011 addr_i  input  ADDR_W  byte address.
REQ-012 wdata_i  input  DATA_W  write data, right-justified.
REQ-013 busy_o  output  1  transaction in progress.
REQ-014 done_o  output  1  one-cycle completion pulse.
REQ-015 rdata_o  output  DATA_W  read result, right-justified and extended; valid while done_o=1.
REQ-016 fault_o  output  1  fault flag, qualified by done_o.
REQ-017 fault_code_o  output  2  fault cause: 1 bus err, 2 timeout, 3 misalign/illegal size.
REQ-018 adr_o  output  ADDR_W  bus address, DATA_W/8-aligned.
REQ-019 dat_o  output  DATA_W  bus write data.
REQ-020 dat_i  input  DATA_W  bus read data.
REQ-021 sel_o  output  DATA_W/8  byte lane enables.
REQ-022 cyc_o, stb_o, we_o  output  1 each  Wishbone classic cycle, strobe and write.
REQ-023 ack_i, err_i  input  1 each  bus acknowledge and bus error.

Function
REQ-024 Byte order SHALL be big-endian: byte offset k within a bus word SHALL occupy lane NB-1-k, where NB=DATA_W/8.
REQ-025 A request SHALL be accepted only when req_i=1 and busy_o=0; the module SHALL latch all request fields and ignore req_i while busy.
REQ-026 FSM states: IDLE, BEAT1, BEAT2, DONE.
REQ-027 Transition on accept: IDLE->BEAT1.
REQ-028 BEAT1 exit on ack: BEAT2 if the access is split, otherwise DONE.
REQ-029 BEAT2 exit on ack: DONE.
REQ-030 DONE->IDLE after one cycle.
REQ-031 Any err_i or timeout SHALL go directly to DONE with fault.
REQ-032 cyc_o, stb_o and we_o SHALL be registered and asserted from the cycle after accept, then held until the terminating ack, err or timeout.
REQ-033 cyc_o SHALL remain high across both beats of a split access.
REQ-034 A split is required when offset+bytes > NB.
REQ-035 Beat 1 of a split SHALL use the aligned floor address with lanes offset..NB-1; beat 2 SHALL use floor+NB with the remaining low-offset lanes.
REQ-036 A beat that does not cross a word boundary, including an unaligned half within one word, SHALL complete in a single beat.
REQ-037 Writes SHALL steer wdata_i bytes to the selected lanes; unselected lanes of dat_o SHALL be 0.
REQ-038 Reads SHALL merge beat data into rdata_o, then zero- or sign-extend according to size_i and signed_i.
REQ-039 Minimum latency: an aligned access with ack in the first stb cycle SHALL give done_o 2 cycles after accept, and a split SHALL give done_o 3 cycles after accept.
REQ-040 err_i SHALL take priority over ack_i in the same cycle; the module SHALL then report fault code 1 and skip any remaining beat.
REQ-041 The timeout counter SHALL reset at each beat start; reaching TIMEOUT SHALL drop cyc_o and stb_o and report fault code 2.
REQ-042 Misalign with ALLOW_MISALIGN=0, or size 3 with DATA_W=32, SHALL raise fault code 3 without any bus cycle and with done_o the cycle after accept.
REQ-043 busy_o SHALL be 1 from the cycle after accept through the DONE cycle.

Reset
REQ-044 rst_i SHALL force IDLE asynchronously.
REQ-045 Reset values: cyc_o, stb_o, we_o, busy_o, done_o and fault_o = 0; fault_code_o = 0; sel_o, adr_o, dat_o and rdata_o = 0.
REQ-046 Reset mid-transaction SHALL abandon the transaction with no done_o pulse.

Structure
REQ-047 Package lsu_pkg SHALL hold the size encodings, the fault codes and the FSM state type.
REQ-048 Lane steering and extension SHALL live in a combinational sub-module lsu_lanes; the FSM and counters SHALL live in lsu_wb.

Verification
REQ-049 Byte read, signed, addr 0x1003, dat_i=0x112233F0 -> sel_o=0001, rdata_o=0xFFFFFFF0, no fault.
REQ-050 Half write 0xBEEF at 0x2002 -> sel_o=0011, dat_o=0x0000BEEF, we_o=1, done_o 2 cycles after accept with 0-wait ack.
REQ-051 Word read at 0x3002, ALLOW_MISALIGN=1 -> beat1 adr 0x3000 sel 0011 dat_i 0x0000AABB; beat2 adr 0x3004 sel 1100 dat_i 0xCCDD0000; rdata_o=0xAABBCCDD; cyc_o continuous.
REQ-052 The same word read with ALLOW_MISALIGN=0 -> cyc_o never asserted, done_o+fault_o with code 3 one cycle after accept.
REQ-053 TIMEOUT=8, ack withheld -> stb_o drops after 8 cycles, fault code 2; ack_i+err_i together on beat1 of a split -> fault code 1, no beat2.
REQ-054 rst_i pulsed during BEAT1 -> cyc_o=0 immediately, no done_o; next request completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the Wishbone load/store unit: access sizes,
// fault causes and the transaction FSM state type.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_BUS_ERR  = 2'd1,
    FC_TIMEOUT  = 2'd2,
    FC_MISALIGN = 2'd3
  } fault_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT1 = 2'd1,
    ST_BEAT2 = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/lsu_lanes.sv
// Big-endian lane steering and read extension. The two bus words of a
// (possibly split) access are treated as one 2*NB-byte big-endian vector.
module lsu_lanes
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NB     = DATA_W / 8,
  parameter int OW     = $clog2(NB)
) (
  input  logic [OW-1:0]     offset,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rd_hi,
  input  logic [DATA_W-1:0] rd_lo,
  output logic              split,
  output logic              bad_size,
  output logic [NB-1:0]     sel_hi,
  output logic [NB-1:0]     sel_lo,
  output logic [DATA_W-1:0] wdat_hi,
  output logic [DATA_W-1:0] wdat_lo,
  output logic [DATA_W-1:0] rdata
);

  localparam int SW = OW + 2;

  logic [SW-1:0]       nbytes;
  logic [SW-1:0]       span;
  logic [SW-1:0]       shamt;
  logic [DATA_W-1:0]   val_mask;
  logic [DATA_W-1:0]   raw;
  logic [2*NB-1:0]     wide_sel;
  logic [2*DATA_W-1:0] wide_w;
  logic                sign_bit;

  always_comb begin
    nbytes   = SW'(1) << size;
    span     = SW'(offset) + nbytes;
    bad_size = (DATA_W == 32) && (size == SZ_DWORD);
    split    = !bad_size && (span > SW'(NB));
    // Byte distance from the end of the access to the end of the window.
    shamt    = bad_size ? '0 : SW'(2 * NB) - span;
    val_mask = ~({DATA_W{1'b1}} << {nbytes, 3'b000});

    wide_sel = ~({(2 * NB){1'b1}} << nbytes);
    wide_sel = wide_sel << shamt;
    wide_w   = {{DATA_W{1'b0}}, wdata & val_mask} << {shamt, 3'b000};

    sel_hi   = wide_sel[2*NB-1:NB];
    sel_lo   = wide_sel[NB-1:0];
    wdat_hi  = wide_w[2*DATA_W-1:DATA_W];
    wdat_lo  = wide_w[DATA_W-1:0];

    raw = DATA_W'({rd_hi, rd_lo} >> {shamt, 3'b000}) & val_mask;
    case (size)
      SZ_BYTE: sign_bit = raw[7];
      SZ_HALF: sign_bit = raw[15];
      SZ_WORD: sign_bit = raw[31];
      default: sign_bit = raw[DATA_W-1];
    endcase
    rdata = (sign_ext && sign_bit) ? (raw | ~val_mask) : raw;
  end

endmodule

// File: rtl/lsu_wb.sv
// Load/store unit mastering a Wishbone classic bus: one or two beats per
// access, optional timeout, faults reported with the completion pulse.
module lsu_wb
  import lsu_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int ALLOW_MISALIGN = 1,
  parameter int TIMEOUT        = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [1:0]          size_i,
  input  logic                signed_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                fault_o,
  output logic [1:0]          fault_code_o,
  output logic [ADDR_W-1:0]   adr_o,
  output logic [DATA_W-1:0]   dat_o,
  input  logic [DATA_W-1:0]   dat_i,
  output logic [DATA_W/8-1:0] sel_o,
  output logic                cyc_o,
  output logic                stb_o,
  output logic                we_o,
  input  logic                ack_i,
  input  logic                err_i
);

  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam int TW = $clog2(TIMEOUT + 2);
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic              we_reg;
  logic [1:0]        size_reg;
  logic              signed_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] hi_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic [TW-1:0]     tmo_reg;
  logic              cyc_reg, stb_reg, bus_we_reg;
  logic              fault_reg;
  fault_e            fault_code_reg, code_next;

  logic              idle, in_beat, beat_next, timeout;
  logic              accept, fault_set, capture_hi, capture_rd;
  logic [OW-1:0]     ln_offset;
  logic [1:0]        ln_size;
  logic              ln_signed;
  logic [DATA_W-1:0] ln_wdata, ln_rd_hi, ln_rdata;
  logic [DATA_W-1:0] wdat_hi, wdat_lo;
  logic [NB-1:0]     sel_hi, sel_lo;
  logic              split, bad_size;

  assign idle      = (state_reg == ST_IDLE);
  assign in_beat   = (state_reg == ST_BEAT1) || (state_reg == ST_BEAT2);
  assign beat_next = (state_next == ST_BEAT1) || (state_next == ST_BEAT2);
  assign timeout   = (TIMEOUT != 0) && (tmo_reg == TO_LAST);

  // While idle the lanes decode the incoming request so the accept decision
  // can see split/illegal size; afterwards they work on the latched fields.
  assign ln_offset = idle ? addr_i[OW-1:0] : addr_reg[OW-1:0];
  assign ln_size   = idle ? size_i : size_reg;
  assign ln_signed = idle ? signed_i : signed_reg;
  assign ln_wdata  = idle ? wdata_i : wdata_reg;
  assign ln_rd_hi  = (state_reg == ST_BEAT1) ? dat_i : hi_reg;

  lsu_lanes #(
    .DATA_W (DATA_W)
  ) u_lanes (
    .offset   (ln_offset),
    .size     (ln_size),
    .sign_ext (ln_signed),
    .wdata    (ln_wdata),
    .rd_hi    (ln_rd_hi),
    .rd_lo    (dat_i),
    .split    (split),
    .bad_size (bad_size),
    .sel_hi   (sel_hi),
    .sel_lo   (sel_lo),
    .wdat_hi  (wdat_hi),
    .wdat_lo  (wdat_lo),
    .rdata    (ln_rdata)
  );

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    fault_set  = 1'b0;
    code_next  = FC_NONE;
    capture_hi = 1'b0;
    capture_rd = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req_i) begin
          accept = 1'b1;
          if (bad_size || (split && ALLOW_MISALIGN == 0)) begin
            state_next = ST_DONE;
            fault_set  = 1'b1;
            code_next  = FC_MISALIGN;
          end else begin
            state_next = ST_BEAT1;
          end
        end
      end
      ST_BEAT1: begin
        if (err_i) begin
          state_next = ST_DONE;
          fault_set  = 1'b1;
          code_next  = FC_BUS_ERR;
        end else if (ack_i) begin
          if (split) begin
            state_next = ST_BEAT2;
            capture_hi = 1'b1;
          end else begin
            state_next = ST_DONE;
            capture_rd = !we_reg;
          end
        end else if (timeout) begin
          state_next = ST_DONE;
          fault_set  = 1'b1;
          code_next  = FC_TIMEOUT;
        end
      end
      ST_BEAT2: begin
        if (err_i) begin
          state_next = ST_DONE;
          fault_set  = 1'b1;
          code_next  = FC_BUS_ERR;
        end else if (ack_i) begin
          state_next = ST_DONE;
          capture_rd = !we_reg;
        end else if (timeout) begin
          state_next = ST_DONE;
          fault_set  = 1'b1;
          code_next  = FC_TIMEOUT;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg      <= ST_IDLE;
      addr_reg       <= '0;
      we_reg         <= 1'b0;
      size_reg       <= '0;
      signed_reg     <= 1'b0;
      wdata_reg      <= '0;
      hi_reg         <= '0;
      rdata_reg      <= '0;
      tmo_reg        <= '0;
      cyc_reg        <= 1'b0;
      stb_reg        <= 1'b0;
      bus_we_reg     <= 1'b0;
      fault_reg      <= 1'b0;
      fault_code_reg <= FC_NONE;
    end else begin
      state_reg  <= state_next;
      cyc_reg    <= beat_next;
      stb_reg    <= beat_next;
      bus_we_reg <= beat_next && (idle ? we_i : we_reg);
      if (accept) begin
        addr_reg       <= addr_i;
        we_reg         <= we_i;
        size_reg       <= size_i;
        signed_reg     <= signed_i;
        wdata_reg      <= wdata_i;
        fault_reg      <= 1'b0;
        fault_code_reg <= FC_NONE;
      end
      if (fault_set) begin
        fault_reg      <= 1'b1;
        fault_code_reg <= code_next;
      end
      if (capture_hi) hi_reg <= dat_i;
      if (capture_rd) rdata_reg <= ln_rdata;
      // Restart the stall counter whenever a new beat (or any state) begins.
      if (state_next != state_reg) tmo_reg <= '0;
      else if (in_beat)            tmo_reg <= tmo_reg + TW'(1);
    end
  end

  always_comb begin
    sel_o = '0;
    dat_o = '0;
    case (state_reg)
      ST_BEAT1: begin
        sel_o = sel_hi;
        dat_o = we_reg ? wdat_hi : '0;
      end
      ST_BEAT2: begin
        sel_o = sel_lo;
        dat_o = we_reg ? wdat_lo : '0;
      end
      default: ;
    endcase
  end

  assign adr_o        = {addr_reg[ADDR_W-1:OW], {OW{1'b0}}}
                      + ((state_reg == ST_BEAT2) ? ADDR_W'(NB) : ADDR_W'(0));
  assign busy_o       = !idle;
  assign done_o       = (state_reg == ST_DONE);
  assign fault_o      = (state_reg == ST_DONE) && fault_reg;
  assign fault_code_o = fault_code_reg;
  assign rdata_o      = rdata_reg;
  assign cyc_o        = cyc_reg;
  assign stb_o        = stb_reg;
  assign we_o         = bus_we_reg;

endmodule

// File: tb/tb_lsu_wb.sv
// Directed bench for lsu_wb: one DUT with splitting and an 8-cycle timeout,
// a second with misaligned accesses faulted.
module tb_lsu_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, req2, we, sgn, ack, err;
  logic [1:0]  size;
  logic [31:0] addr, wdata, dat_i;

  logic        busy, done, fault, cyc, stb, bwe;
  logic [1:0]  fcode;
  logic [31:0] adr, dat_o, rdata;
  logic [3:0]  sel;

  logic        busy2, done2, fault2, cyc2, stb2, bwe2;
  logic [1:0]  fcode2;
  logic [31:0] adr2, dat_o2, rdata2;
  logic [3:0]  sel2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  lsu_wb #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGN(1), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .size_i(size),
    .signed_i(sgn), .addr_i(addr), .wdata_i(wdata), .busy_o(busy),
    .done_o(done), .rdata_o(rdata), .fault_o(fault), .fault_code_o(fcode),
    .adr_o(adr), .dat_o(dat_o), .dat_i(dat_i), .sel_o(sel), .cyc_o(cyc),
    .stb_o(stb), .we_o(bwe), .ack_i(ack), .err_i(err)
  );

  lsu_wb #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGN(0), .TIMEOUT(0)) dut2 (
    .clk_i(clk), .rst_i(rst), .req_i(req2), .we_i(we), .size_i(size),
    .signed_i(sgn), .addr_i(addr), .wdata_i(wdata), .busy_o(busy2),
    .done_o(done2), .rdata_o(rdata2), .fault_o(fault2), .fault_code_o(fcode2),
    .adr_o(adr2), .dat_o(dat_o2), .dat_i(dat_i), .sel_o(sel2), .cyc_o(cyc2),
    .stb_o(stb2), .we_o(bwe2), .ack_i(ack), .err_i(err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Drives a request for one cycle; returns at the first beat's mid-cycle.
  task automatic issue(input logic to2, input logic w, input logic [1:0] sz,
                       input logic s, input logic [31:0] a, input logic [31:0] wd);
    we = w; size = sz; sgn = s; addr = a; wdata = wd;
    if (to2) req2 = 1'b1;
    else     req  = 1'b1;
    @(negedge clk);
    req = 1'b0; req2 = 1'b0;
    $display("req %s we=%0d size=%0d signed=%0d addr=0x%08h wdata=0x%08h",
             to2 ? "dut2" : "dut", w, sz, s, a, wd);
  endtask

  task automatic bus(input logic a, input logic e, input logic [31:0] d);
    ack = a; err = e; dat_i = d;
    @(negedge clk);
    ack = 1'b0; err = 1'b0; dat_i = '0;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; req2 = 1'b0; we = 1'b0; size = '0; sgn = 1'b0;
    addr = '0; wdata = '0; ack = 1'b0; err = 1'b0; dat_i = '0;
    repeat (2) @(negedge clk);
    chk("rst cyc",   64'(cyc),   64'd0);
    chk("rst busy",  64'(busy),  64'd0);
    chk("rst done",  64'(done),  64'd0);
    chk("rst fault", 64'(fault), 64'd0);
    chk("rst fcode", 64'(fcode), 64'd0);
    chk("rst sel",   64'(sel),   64'd0);
    chk("rst adr",   64'(adr),   64'd0);
    chk("rst dat",   64'(dat_o), 64'd0);
    chk("rst rdata", 64'(rdata), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // signed byte read at lane 0
    issue(1'b0, 1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'h0);
    chk("brd busy", 64'(busy), 64'd1);
    chk("brd cyc",  64'(cyc),  64'd1);
    chk("brd we",   64'(bwe),  64'd0);
    chk("brd adr",  64'(adr),  64'h1000);
    chk("brd sel",  64'(sel),  64'h1);
    chk("brd done early", 64'(done), 64'd0);
    bus(1'b1, 1'b0, 32'h1122_33F0);
    chk("brd done",  64'(done),  64'd1);
    chk("brd rdata", 64'(rdata), 64'hFFFF_FFF0);
    chk("brd fault", 64'(fault), 64'd0);
    chk("brd cyc off", 64'(cyc), 64'd0);
    @(negedge clk);
    chk("brd idle", 64'(busy), 64'd0);

    // half write, upper wdata bits must not leak
    issue(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h1234_BEEF);
    chk("hwr sel", 64'(sel),   64'h3);
    chk("hwr dat", 64'(dat_o), 64'h0000_BEEF);
    chk("hwr we",  64'(bwe),   64'd1);
    chk("hwr adr", 64'(adr),   64'h2000);
    bus(1'b1, 1'b0, 32'h0);
    chk("hwr done", 64'(done), 64'd1);
    @(negedge clk);

    // byte write at offset 0 lands in the top lane
    issue(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_4000, 32'h0000_00A5);
    chk("bwr sel", 64'(sel),   64'h8);
    chk("bwr dat", 64'(dat_o), 64'hA500_0000);
    bus(1'b1, 1'b0, 32'h0);
    @(negedge clk);

    // unaligned half inside one word: single beat
    issue(1'b0, 1'b0, 2'd1, 1'b0, 32'h0000_5001, 32'h0);
    chk("uhr sel", 64'(sel), 64'h6);
    chk("uhr adr", 64'(adr), 64'h5000);
    bus(1'b1, 1'b0, 32'h00C3_D400);
    chk("uhr done",  64'(done),  64'd1);
    chk("uhr rdata", 64'(rdata), 64'h0000_C3D4);
    @(negedge clk);

    // signed half read
    issue(1'b0, 1'b0, 2'd1, 1'b1, 32'h0000_6000, 32'h0);
    chk("shr sel", 64'(sel), 64'hC);
    bus(1'b1, 1'b0, 32'h8001_7777);
    chk("shr rdata", 64'(rdata), 64'hFFFF_8001);
    @(negedge clk);

    // split word read
    issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_3002, 32'h0);
    chk("spr b1 adr", 64'(adr), 64'h3000);
    chk("spr b1 sel", 64'(sel), 64'h3);
    bus(1'b1, 1'b0, 32'h0000_AABB);
    chk("spr b2 cyc",  64'(cyc),  64'd1);
    chk("spr b2 adr",  64'(adr),  64'h3004);
    chk("spr b2 sel",  64'(sel),  64'hC);
    chk("spr b2 done", 64'(done), 64'd0);
    bus(1'b1, 1'b0, 32'hCCDD_0000);
    chk("spr done",  64'(done),  64'd1);
    chk("spr rdata", 64'(rdata), 64'hAABB_CCDD);
    chk("spr fault", 64'(fault), 64'd0);
    @(negedge clk);

    // split word write
    issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_7003, 32'h1122_3344);
    chk("spw b1 adr", 64'(adr),   64'h7000);
    chk("spw b1 sel", 64'(sel),   64'h1);
    chk("spw b1 dat", 64'(dat_o), 64'h0000_0011);
    bus(1'b1, 1'b0, 32'h0);
    chk("spw b2 adr", 64'(adr),   64'h7004);
    chk("spw b2 sel", 64'(sel),   64'hE);
    chk("spw b2 dat", 64'(dat_o), 64'h2233_4400);
    bus(1'b1, 1'b0, 32'h0);
    chk("spw done", 64'(done), 64'd1);
    @(negedge clk);

    // dword on a 32-bit bus is illegal
    issue(1'b0, 1'b0, 2'd3, 1'b0, 32'h0000_8000, 32'h0);
    chk("ill done",  64'(done),  64'd1);
    chk("ill fault", 64'(fault), 64'd1);
    chk("ill fcode", 64'(fcode), 64'd3);
    chk("ill cyc",   64'(cyc),   64'd0);
    @(negedge clk);

    // misalign fault without bus cycle
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_3002, 32'h0);
    chk("mis done",  64'(done2),  64'd1);
    chk("mis fault", 64'(fault2), 64'd1);
    chk("mis fcode", 64'(fcode2), 64'd3);
    chk("mis cyc",   64'(cyc2),   64'd0);
    @(negedge clk);
    chk("mis cyc after", 64'(cyc2), 64'd0);

    // in-word unaligned half is still fine without misalign support
    issue(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_3001, 32'h0);
    chk("nm sel", 64'(sel2), 64'h6);
    bus(1'b1, 1'b0, 32'h00AB_CD00);
    chk("nm done",  64'(done2),  64'd1);
    chk("nm fault", 64'(fault2), 64'd0);
    chk("nm rdata", 64'(rdata2), 64'h0000_ABCD);
    @(negedge clk);

    // ack withheld: stb lasts 8 cycles then timeout fault
    issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_9000, 32'h0);
    for (int i = 1; i < 8; i++) @(negedge clk);
    chk("tmo stb 8th", 64'(stb), 64'd1);
    @(negedge clk);
    chk("tmo stb off", 64'(stb),   64'd0);
    chk("tmo cyc off", 64'(cyc),   64'd0);
    chk("tmo done",    64'(done),  64'd1);
    chk("tmo fault",   64'(fault), 64'd1);
    chk("tmo fcode",   64'(fcode), 64'd2);
    @(negedge clk);

    // err wins over ack on beat 1 of a split
    issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_9002, 32'h0);
    bus(1'b1, 1'b1, 32'hFFFF_FFFF);
    chk("err done",  64'(done),  64'd1);
    chk("err fault", 64'(fault), 64'd1);
    chk("err fcode", 64'(fcode), 64'd1);
    chk("err cyc",   64'(cyc),   64'd0);
    @(negedge clk);
    chk("err no b2", 64'(cyc), 64'd0);

    // asynchronous reset during beat 1
    issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_A000, 32'h0);
    chk("rmid cyc", 64'(cyc), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rmid cyc now",  64'(cyc),  64'd0);
    chk("rmid busy now", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rmid no done", 64'(done), 64'd0);
    issue(1'b0, 1'b0, 2'd0, 1'b0, 32'h0000_B002, 32'h0);
    chk("rec sel", 64'(sel), 64'h2);
    bus(1'b1, 1'b0, 32'h0000_F000);
    chk("rec done",  64'(done),  64'd1);
    chk("rec rdata", 64'(rdata), 64'h0000_00F0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
